// File: rtl/fetch_stage.sv
// Instruction-fetch front end. Owns the PC and issues at most one outstanding
// request on the instruction bus. A single-entry buffer holds the fetched
// instruction for decode behind a valid/ready handshake. Redirects are accepted
// at any point of a bus transaction. A misaligned PC never reaches the bus and
// is reported to decode as an address error.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        reset,

    // Instruction bus request / response
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,

    // Fetch stream redirect from branch / exception logic
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    // Buffered instruction towards decode
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_exc
);

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StFull
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        buf_exc_q, buf_exc_d;

    logic        pc_aligned;
    logic        data_done;
    logic        drop_data;

    assign pc_aligned = (pc_q[1:0] == 2'b00);

    // A response completing this cycle is thrown away when it belongs to a
    // fetch stream that has already been (or is now being) redirected.
    assign drop_data = kill_q | redirect_valid;

    // Bus request is a function of state only. While kill is set in FETCH the
    // bus still holds the pre-redirect request, so keep presenting it even if
    // the new pc is misaligned; the address must not move before addr_ok.
    always_comb begin
        ireq_valid = (state_q == StFetch) & (kill_q | pc_aligned);
        ireq_addr  = kill_q ? req_addr_q : pc_q;
    end

    // Decode-side outputs come straight from the buffer registers.
    always_comb begin
        out_valid = (state_q == StFull);
        out_pc    = buf_pc_q;
        out_instr = buf_instr_q;
        out_exc   = buf_exc_q;
    end

    // Next-state logic for the fetch FSM, pc, kill flag and output buffer.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        req_addr_d  = req_addr_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        buf_exc_d   = buf_exc_q;
        data_done   = 1'b0;

        case (state_q)
            StFetch: begin
                // Remember whatever is on the bus so WAIT knows the fetched PC.
                req_addr_d = ireq_addr;
                if (ireq_valid) begin
                    if (iresp_addr_ok && iresp_data_ok) begin
                        data_done = 1'b1;
                        if (drop_data) begin
                            kill_d = 1'b0;
                            if (redirect_valid) begin
                                pc_d = redirect_pc;
                            end
                        end else begin
                            buf_pc_d    = ireq_addr;
                            buf_instr_d = iresp_data;
                            buf_exc_d   = 1'b0;
                            state_d     = StFull;
                        end
                    end else if (iresp_addr_ok) begin
                        state_d = StWait;
                        if (redirect_valid) begin
                            kill_d = 1'b1;
                            pc_d   = redirect_pc;
                        end
                    end else if (redirect_valid) begin
                        // Request is still pending on the bus: it must be
                        // completed and its data discarded.
                        kill_d = 1'b1;
                        pc_d   = redirect_pc;
                    end
                end else begin
                    // Misaligned pc: nothing goes out on the bus.
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = 32'h0;
                        buf_exc_d   = 1'b1;
                        state_d     = StFull;
                    end
                end
            end

            StWait: begin
                if (iresp_data_ok) begin
                    data_done = 1'b1;
                    if (drop_data) begin
                        kill_d  = 1'b0;
                        state_d = StFetch;
                        if (redirect_valid) begin
                            pc_d = redirect_pc;
                        end
                    end else begin
                        buf_pc_d    = req_addr_q;
                        buf_instr_d = iresp_data;
                        buf_exc_d   = 1'b0;
                        state_d     = StFull;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                    pc_d   = redirect_pc;
                end
            end

            StFull: begin
                // Redirect wins over a simultaneous fire: the buffered
                // instruction is flushed and counts as not consumed.
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = StFetch;
                end else if (out_ready) begin
                    pc_d    = buf_pc_q + 32'd4;
                    state_d = StFetch;
                end
            end

            default: begin
                state_d = StFetch;
                kill_d  = 1'b0;
            end
        endcase

        // data_ok without an outstanding request falls through the cases
        // above untouched and is therefore ignored.
        if (data_done && (state_d == StWait)) begin
            state_d = StFetch;
        end
    end

    // State registers with synchronous reset; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            req_addr_q  <= RESET_PC;
            buf_pc_q    <= 32'h0;
            buf_instr_q <= 32'h0;
            buf_exc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            req_addr_q  <= req_addr_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_exc_q   <= buf_exc_d;
        end
    end

endmodule
